// File: rtl/hbridge_pkg.sv
// Shared types for the H-bridge dead-time guard: FSM states, the
// remembered drive leg and the default dead-time length in PCLK cycles.
package hbridge_pkg;

    // Default number of both-low cycles enforced on a leg change.
    localparam int DEADTIME_CYCLES_DEFAULT = 100;

    // ST_FAULT is only reachable when HBRIDGE_FAULT_LATCH_EN is defined.
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DRV_A = 3'd1,
        ST_DRV_B = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } hb_state_t;

    typedef enum logic [1:0] {
        LEG_NONE = 2'd0,
        LEG_A    = 2'd1,
        LEG_B    = 2'd2
    } hb_leg_t;

    // Leg that a given state drives; LEG_NONE when both legs are low.
    function automatic hb_leg_t leg_of(input hb_state_t st);
        hb_leg_t leg;
        leg = LEG_NONE;
        if (st == ST_DRV_A) leg = LEG_A;
        if (st == ST_DRV_B) leg = LEG_B;
        return leg;
    endfunction

endpackage

// File: rtl/hbridge_deadtime_cnt.sv
// Saturating count of consecutive both-low output cycles.
// Ports: clk, rst (sync, active-high), clr (zero the count),
//        inc (count one more low cycle), done (count reached the dead time).
module hbridge_deadtime_cnt
    import hbridge_pkg::*;
#(
    parameter int DEADTIME_CYCLES = DEADTIME_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int CW = $clog2(DEADTIME_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEADTIME_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hbridge_deadtime_guard.sv
// Shoot-through and dead-time guard for one side of the H-bridge.
// Ports: PCLK, PRESET (sync, active-high), EN (drive enable),
//        IN_HB1/IN_HB2 (leg requests), FAULT_CLR (only with
//        HBRIDGE_FAULT_LATCH_EN), HB1/HB2 (registered leg drives),
//        DEAD_ACTIVE (opposite-leg request held off), FAULT.
// Macro HBRIDGE_FAULT_LATCH_EN: shoot-through latches a sticky FAULT
// state, released by FAULT_CLR with both requests low. Without it,
// FAULT is a one-cycle registered copy of the shoot-through request.
module hbridge_deadtime_guard
    import hbridge_pkg::*;
#(
    parameter int DEADTIME_CYCLES = DEADTIME_CYCLES_DEFAULT
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic EN,
    input  logic IN_HB1,
    input  logic IN_HB2,
`ifdef HBRIDGE_FAULT_LATCH_EN
    input  logic FAULT_CLR,
`endif
    output logic HB1,
    output logic HB2,
    output logic DEAD_ACTIVE,
    output logic FAULT
);

    hb_state_t state_q;
    hb_state_t state_d;
    hb_state_t drive_next;
    hb_leg_t   last_leg_q;
    hb_leg_t   last_leg_d;

    logic hb1_q;
    logic hb1_d;
    logic hb2_q;
    logic hb2_d;
    logic dead_q;
    logic dead_d;
    logic fault_q;
    logic fault_d;

    logic req_a;
    logic req_b;
    logic shoot;
    logic grant_a;
    logic grant_b;
    logic cnt_done;
    logic cnt_clr;
    logic cnt_inc;
    logic leave_fault;

    always_comb begin
        req_a   = IN_HB1 & ~IN_HB2;
        req_b   = IN_HB2 & ~IN_HB1;
        shoot   = IN_HB1 & IN_HB2;
        grant_a = (last_leg_q == LEG_A) | cnt_done;
        grant_b = (last_leg_q == LEG_B) | cnt_done;
    end

    // Common next state for OFF, DRV_A, DRV_B and DEAD with EN high.
    always_comb begin
        drive_next = ST_OFF;
        unique case (1'b1)
            req_a:   drive_next = grant_a ? ST_DRV_A : ST_DEAD;
            req_b:   drive_next = grant_b ? ST_DRV_B : ST_DEAD;
            default: drive_next = ST_OFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        leave_fault = 1'b0;
`ifdef HBRIDGE_FAULT_LATCH_EN
        if (state_q == ST_FAULT) begin
            if (FAULT_CLR && !IN_HB1 && !IN_HB2) begin
                state_d     = ST_OFF;
                leave_fault = 1'b1;
            end
        end else if (shoot) begin
            state_d = ST_FAULT;
        end else if (!EN) begin
            state_d = ST_OFF;
        end else begin
            state_d = drive_next;
        end
`else
        // Shoot-through decodes as no request, so only EN matters here.
        if (!EN) begin
            state_d = ST_OFF;
        end else begin
            state_d = drive_next;
        end
`endif
    end

    always_comb begin
        last_leg_d = last_leg_q;
        if (leg_of(state_d) != LEG_NONE) begin
            last_leg_d = leg_of(state_d);
        end
        hb1_d  = (state_d == ST_DRV_A);
        hb2_d  = (state_d == ST_DRV_B);
        dead_d = (state_d == ST_DEAD);
`ifdef HBRIDGE_FAULT_LATCH_EN
        fault_d = (state_d == ST_FAULT);
`else
        fault_d = shoot;
`endif
    end

    // The counter tracks the outputs being registered this edge, so a
    // value of DEADTIME_CYCLES means that many low cycles already shown.
    always_comb begin
        cnt_clr = hb1_d | hb2_d | leave_fault;
        cnt_inc = ~cnt_clr;
    end

    hbridge_deadtime_cnt #(
        .DEADTIME_CYCLES(DEADTIME_CYCLES)
    ) u_cnt (
        .clk (PCLK),
        .rst (PRESET),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .done(cnt_done)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_OFF;
            last_leg_q <= LEG_NONE;
            hb1_q      <= 1'b0;
            hb2_q      <= 1'b0;
            dead_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_leg_q <= last_leg_d;
            hb1_q      <= hb1_d;
            hb2_q      <= hb2_d;
            dead_q     <= dead_d;
            fault_q    <= fault_d;
        end
    end

    assign HB1         = hb1_q;
    assign HB2         = hb2_q;
    assign DEAD_ACTIVE = dead_q;
    assign FAULT       = fault_q;

endmodule

// File: tb/tb_hbridge_deadtime_guard.sv
// Scoreboard bench for hbridge_deadtime_guard with DEADTIME_CYCLES=4.
// Directed scenarios followed by randomized drive sequences.
module tb_hbridge_deadtime_guard;

    localparam int D = 4;

    logic PCLK = 1'b0;
    logic PRESET;
    logic EN;
    logic IN_HB1;
    logic IN_HB2;
    logic FAULT_CLR;
    logic HB1;
    logic HB2;
    logic DEAD_ACTIVE;
    logic FAULT;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [3:0] exp_q[$];

    // Reference model: remembered leg, length of current both-low run,
    // and the latched-fault flag.
    int last_leg = 0;
    int low_run  = 0;
    bit latched  = 1'b0;

    always #5 PCLK = ~PCLK;

    hbridge_deadtime_guard #(
        .DEADTIME_CYCLES(D)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .EN         (EN),
        .IN_HB1     (IN_HB1),
        .IN_HB2     (IN_HB2),
`ifdef HBRIDGE_FAULT_LATCH_EN
        .FAULT_CLR  (FAULT_CLR),
`endif
        .HB1        (HB1),
        .HB2        (HB2),
        .DEAD_ACTIVE(DEAD_ACTIVE),
        .FAULT      (FAULT)
    );

    // Drive one cycle of inputs, push the outputs expected after the
    // next rising edge, then move to just past that edge.
    task automatic step(input bit rst, input bit en, input bit a,
                        input bit b, input bit clr);
        bit o1, o2, dd, ff, exit_f, blocked, sh;
        int rq;
        PRESET    = rst;
        EN        = en;
        IN_HB1    = a;
        IN_HB2    = b;
        FAULT_CLR = clr;
        o1 = 0; o2 = 0; dd = 0; ff = 0; exit_f = 0; blocked = 0;
        sh = a & b;
        rq = (a && !b) ? 1 : ((b && !a) ? 2 : 0);
        if (rst) begin
            last_leg = 0;
            low_run  = 0;
            latched  = 0;
        end else begin
`ifdef HBRIDGE_FAULT_LATCH_EN
            if (latched) begin
                if (clr && !a && !b) begin
                    latched = 0;
                    exit_f  = 1;
                end
            end else if (sh) begin
                latched = 1;
            end
            ff      = latched;
            blocked = latched;
`else
            ff = sh;
`endif
            if (!blocked && en && rq != 0) begin
                if (last_leg == rq || low_run >= D) begin
                    o1 = (rq == 1);
                    o2 = (rq == 2);
                    last_leg = rq;
                end else begin
                    dd = 1;
                end
            end
            if (o1 || o2 || exit_f) low_run = 0;
            else low_run = low_run + 1;
        end
        exp_q.push_back({o1, o2, dd, ff});
        @(posedge PCLK);
        #3;
    endtask

    // Monitor: one set of outputs per rising edge.
    initial begin
        logic [3:0] got;
        logic [3:0] exp;
        forever begin
            @(posedge PCLK);
            #1;
            cyc++;
            got = {HB1, HB2, DEAD_ACTIVE, FAULT};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL outs cyc=%0d got=%b exp=<none queued>",
                         cyc, got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL outs cyc=%0d got=%b exp=%b (HB1 HB2 DEAD FAULT)",
                             cyc, got, exp);
                end
            end
            n_cmp++;
            if (HB1 === 1'b1 && HB2 === 1'b1) begin
                n_bad++;
                $display("FAIL overlap cyc=%0d got HB1&HB2=1 exp=0", cyc);
            end
        end
    end

    initial begin
        int hold, mode, p;
        bit pwm, a, b, en, rst, clr;

        // Reset two cycles, then hold leg A through the first dead time.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
        // PWM on leg A: 3 high / 2 low.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
            for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0);
        end
        // Reversal to leg B with a held request.
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 0);
        // Cancelled reversal to A, then back to B with no wait.
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
        // One shoot-through cycle while driving B.
        step(0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 0);
        // Reset mid-drive, then leg A waits the full dead time.
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0);
        // Enable drop while driving.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        // Dead-time boundary: reversal after exactly D-1 and D low cycles.
        for (int i = 0; i < D - 1; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
        for (int i = 0; i < D; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);

        hold = 0;
        mode = 0;
        pwm  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                p = int'($urandom_range(0, 99));
                mode = (p < 38) ? 1 : ((p < 76) ? 2 : ((p < 92) ? 0 : 3));
                hold = (mode == 3) ? 1 : int'($urandom_range(1, 14));
                pwm  = ($urandom_range(0, 3) == 0);
            end
            hold--;
            a = (mode == 1) || (mode == 3);
            b = (mode == 2) || (mode == 3);
            if (pwm && $urandom_range(0, 2) == 0) begin
                a = 0;
                b = 0;
            end
            en  = ($urandom_range(0, 39) != 0);
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 3) == 0);
            step(rst, en, a, b, clr);
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d queued exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
